// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic master pins for wb_cmd_master.
// The master modport is the DUT view; the slave modport is the view of whoever drives commands and acks.
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
  // once valid is raised its payload stays stable until that transfer.
  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream,
// one outstanding transfer, aborting with rsp_err when no ack arrives within TIMEOUT cycles.
module wb_cmd_master #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   wb_cmd_master_if.master    bus,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign bus.cmd_ready = (state == IDLE);
   assign dbg_state     = state;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.wbm_cyc_o <= 1'b0;
         bus.wbm_stb_o <= 1'b0;
         bus.wbm_we_o  <= 1'b0;
         bus.wbm_sel_o <= '0;
         bus.wbm_adr_o <= '0;
         bus.wbm_dat_o <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_dat   <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.wbm_cyc_o <= 1'b1;
                  bus.wbm_stb_o <= 1'b1;
                  bus.wbm_we_o  <= bus.cmd_we;
                  bus.wbm_sel_o <= bus.cmd_sel;
                  bus.wbm_adr_o <= bus.cmd_adr;
                  bus.wbm_dat_o <= bus.cmd_dat;
                  cnt           <= '0;
                  state         <= BUS;
               end
            end
            BUS: begin
               // An ack in the final allowed cycle still completes normally.
               if (bus.wbm_ack_i || cnt == CNT_LAST) begin
                  bus.wbm_cyc_o <= 1'b0;
                  bus.wbm_stb_o <= 1'b0;
                  bus.wbm_we_o  <= 1'b0;
                  bus.wbm_sel_o <= '0;
                  bus.wbm_adr_o <= '0;
                  bus.wbm_dat_o <= '0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= ~bus.wbm_ack_i;
                  bus.rsp_dat   <= (bus.wbm_ack_i && !bus.wbm_we_o) ? bus.wbm_dat_i : 32'h0;
                  state         <= RESP;
               end
               if (!bus.wbm_ack_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
